sevenseg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver that replaces the single-digit active-low decoder in the traffic-controller display path. It captures a binary value on a load strobe and converts it to BCD sequentially (shift-add-3). It then time-multiplexes NUM_DIGITS digits onto one shared segment bus with one-hot digit enables. It adds leading-zero suppression, overflow indication and a blink mode, used for the pedestrian countdown and the light-phase timer.

---
 rtl/sevenseg_scan_driver_if.sv | 28 ++
 rtl/sevenseg_scan_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Bus bundle for the multiplexed seven-segment driver: value/strobe and
// display-mode controls in, segment/enable bus and status out.
interface sevenseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
);
    logic [BIN_W-1:0]      value;
    logic                  load;
    logic                  blank_lz;
    logic                  blank_all;
    logic                  blink_en;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  busy;
    logic                  ovf;

    // Controller side: supplies the number and display modes.
    modport master (
        output value, load, blank_lz, blank_all, blink_en,
        input  seg, an, busy, ovf
    );

    // Driver side.
    modport slave (
        input  value, load, blank_lz, blank_all, blink_en,
        output seg, an, busy, ovf
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD conversion
// (shift-add-3), one-hot digit scanning, leading-zero suppression, overflow
// dash and blink. seg/an are registered so glyph and enable switch together.
module sevenseg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int BIN_W          = 14,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input logic               clk,
    input logic               rst,
    sevenseg_scan_driver_if.slave bus
);
    // Enough nibbles for any BIN_W-bit value (log10(2) < 1/3), never fewer
    // than the displayed digits, so the add-3 step can never wrap.
    localparam int BCD_N = (NUM_DIGITS > BIN_W / 3 + 1) ? NUM_DIGITS : BIN_W / 3 + 1;
    localparam int SW    = BCD_N * 4 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PW    = $clog2(SCAN_DIV);
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW_AN ? '1 : '0;

    function automatic logic [63:0] pow10(input int k);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < k; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    // Active-high glyphs, bit 0 = segment a; anything above 9 stays dark.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [1:0]              state_q, state_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [BCD_N*4-1:0]      bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pend_q, pend_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic [NUM_DIGITS*4-1:0] disp_q, disp_d;
    logic [SW-1:0]           shifted;
    logic                    ovf_now;

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic                    presc_wrap, idx_wrap, frame_wrap;

    logic [6:0]              seg_q, seg_d, seg_raw;
    logic [NUM_DIGITS-1:0]   an_q, an_d, an_raw;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   upper_zero;

    assign ovf_now = (64'(bus.value) >= OVF_LIMIT);

    genvar gi;
    generate
        for (gi = 0; gi < BCD_N; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_q[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_q} << 1;

    // Conversion FSM; a load strobe restarts from any state.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        if (bus.load) begin
            bin_d   = bus.value;
            bcd_d   = '0;
            cnt_d   = CNT_W'(BIN_W);
            pend_d  = ovf_now;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    bcd_d = shifted[SW-1:BIN_W];
                    bin_d = shifted[BIN_W-1:0];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_d  = bcd_q[NUM_DIGITS*4-1:0];
                    ovf_d   = pend_q;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    // Scan timing: prescaler -> digit index -> frame counter -> blink phase.
    always_comb begin
        presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
        idx_wrap   = (idx_q == IW'(NUM_DIGITS - 1));
        frame_wrap = (frame_q == FW'(BLINK_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        frame_d    = frame_q;
        phase_d    = phase_q;
        if (presc_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + IW'(1);
            if (idx_wrap) begin
                frame_d = frame_wrap ? '0 : frame_q + FW'(1);
                if (frame_wrap) phase_d = ~phase_q;
            end
        end
    end

    // Scan counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    // upper_zero[i]: display nibbles i..top are all zero (leading-zero run).
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            upper_zero[i] = (nib[i] == 4'd0) && upper_zero[i+1];
    end

    // Glyph selection in priority order, polarity applied last.
    always_comb begin
        seg_raw = 7'h00;
        an_raw  = '0;
        if (!(bus.blank_all || (bus.blink_en && phase_q))) begin
            an_raw = NUM_DIGITS'(1) << idx_q;
            if (ovf_q)
                seg_raw = 7'b1000000;
            else if (bus.blank_lz && (idx_q != '0) && upper_zero[idx_q])
                seg_raw = 7'h00;
            else
                seg_raw = glyph(nib[idx_q]);
        end
        seg_d = ACTIVE_LOW_SEG ? ~seg_raw : seg_raw;
        an_d  = ACTIVE_LOW_AN ? ~an_raw : an_raw;
    end

    // Output registers: segment bus and enables switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: a decimal-arithmetic reference model
// predicts seg/an/busy/ovf every cycle, with literal glyph checks on top.
module tb_sevenseg_scan_driver;
    localparam int ND = 4;
    localparam int BW = 14;
    localparam int SD = 4;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sevenseg_scan_driver_if #(.NUM_DIGITS(ND), .BIN_W(BW)) ifc();

    sevenseg_scan_driver #(
        .NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .BLINK_DIV(BD),
        .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    // Active-high glyph per decimal digit, bit 0 = segment a.
    logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int vectors = 0;
    int miscompares = 0;

    // Model: edges since reset release, committed number, pending load.
    int n;
    int disp;
    bit movf, mbusy, mpend;
    int pval, cd;

    function automatic int p10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; disp = 0; movf = 0; mbusy = 0; mpend = 0; pval = 0; cd = 0;
    endtask

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic step(input bit ld, input int v);
        int idx, ph, d;
        logic [6:0] es;
        logic [3:0] ea;
        @(negedge clk);
        ifc.load  = ld;
        ifc.value = 14'(v);
        n++;
        idx = ((n - 1) / SD) % ND;
        ph  = (((n - 1) / (SD * ND)) / BD) % 2;
        if (ifc.blank_all || (ifc.blink_en && ph == 1)) begin
            es = 7'h7F;
            ea = 4'hF;
        end else begin
            ea = ~(4'(1) << idx);
            d  = (disp / p10(idx)) % 10;
            if (movf)
                es = ~7'h40;
            else if (ifc.blank_lz && idx > 0 && disp < p10(idx))
                es = 7'h7F;
            else
                es = ~glyph_tab[d];
        end
        if (ld) begin
            pval = v; cd = BW + 1; mbusy = 1; mpend = 1;
        end else if (mpend) begin
            cd--;
            if (cd == 0) begin
                disp  = pval % p10(ND);
                movf  = (pval >= p10(ND));
                mbusy = 0;
                mpend = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("seg", 32'(ifc.seg), 32'(es));
        chk("an", 32'(ifc.an), 32'(ea));
        chk("busy", 32'(ifc.busy), 32'(mbusy));
        chk("ovf", 32'(ifc.ovf), 32'(movf));
        $display("edge %0d load=%0d value=%0d seg=%b an=%b busy=%0d ovf=%0d",
                 n, ld, v, ifc.seg, ifc.an, ifc.busy, ifc.ovf);
        ifc.load = 1'b0;
    endtask

    // Async reset between edges, check immediately, release after a posedge.
    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_ovf", 32'(ifc.ovf), 32'd0);
        chk("rst_seg", 32'(ifc.seg), 32'h7F);
        chk("rst_an", 32'(ifc.an), 32'hF);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_digit(input int dg, input logic [6:0] exp, input string name);
        bit found = 0;
        for (int i = 0; i < 2 * SD * ND && !found; i++) begin
            step(0, 0);
            if (ifc.an == ~(4'(1) << dg)) begin
                found = 1;
                chk(name, 32'(ifc.seg), 32'(exp));
            end
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: digit %0d never enabled, got an=%b", name, dg, ifc.an);
        end
    endtask

    // Load v and count cycles busy stays high (bounded).
    task automatic busy_len(input int v, input string name);
        int c = 0;
        step(1, v);
        while (ifc.busy && c < 40) begin
            c++;
            step(0, 0);
        end
        chk(name, 32'(c), 32'd15);
    endtask

    initial begin
        bit ld;
        int v;
        rst = 1'b1;
        ifc.value = '0; ifc.load = 1'b0;
        ifc.blank_lz = 1'b0; ifc.blank_all = 1'b0; ifc.blink_en = 1'b0;
        model_reset();
        apply_reset();

        // Reset / scan of an all-zero display.
        step(0, 0);
        chk("first_an", 32'(ifc.an), 32'b1110);
        repeat (20) step(0, 0);
        ifc.blank_lz = 1'b1;
        wait_digit(2, 7'h7F, "lz_zero_d2");
        wait_digit(0, 7'b1000000, "zero_d0");
        ifc.blank_lz = 1'b0;

        // Conversion of 1234.
        busy_len(1234, "busy_1234");
        chk("ovf_1234", 32'(ifc.ovf), 32'd0);
        wait_digit(0, 7'b0011001, "g1234_d0");
        wait_digit(1, 7'b0110000, "g1234_d1");
        wait_digit(2, 7'b0100100, "g1234_d2");
        wait_digit(3, 7'b1111001, "g1234_d3");

        // Leading zeros on 7.
        ifc.blank_lz = 1'b1;
        busy_len(7, "busy_7");
        wait_digit(0, 7'b1111000, "g7_d0");
        wait_digit(1, 7'h7F, "g7_d1_blank");
        wait_digit(3, 7'h7F, "g7_d3_blank");
        ifc.blank_lz = 1'b0;

        // Overflow and its clearing.
        busy_len(12000, "busy_12000");
        chk("ovf_set", 32'(ifc.ovf), 32'd1);
        wait_digit(1, 7'b0111111, "dash_d1");
        busy_len(5, "busy_5");
        chk("ovf_clear", 32'(ifc.ovf), 32'd0);

        // Restart: 9999 superseded by 42 three cycles later.
        step(1, 9999);
        step(0, 0);
        step(0, 0);
        busy_len(42, "restart_busy");
        wait_digit(0, 7'b0100100, "g42_d0");
        wait_digit(1, 7'b0011001, "g42_d1");

        // Reset mid-conversion.
        step(1, 1234);
        repeat (5) step(0, 0);
        apply_reset();
        repeat (20) step(0, 0);

        // Blink and blank_all.
        ifc.blink_en = 1'b1;
        repeat (140) step(0, 0);
        ifc.blink_en = 1'b0;
        ifc.blank_all = 1'b1;
        step(0, 0);
        chk("blank_all_an", 32'(ifc.an), 32'hF);
        ifc.blank_all = 1'b0;

        // Randomised traffic.
        repeat (3000) begin
            ld = ($urandom_range(39) == 0);
            v  = ($urandom_range(1) == 1) ? int'($urandom_range(9999)) : int'($urandom_range(16383));
            if ($urandom_range(63) == 0) ifc.blank_lz = ~ifc.blank_lz;
            ifc.blank_all = ($urandom_range(49) == 0);
            if ($urandom_range(199) == 0) ifc.blink_en = ~ifc.blink_en;
            if ($urandom_range(999) == 0) apply_reset();
            step(ld, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
